// File: rtl/fht_frame_sched.sv
// Frame scheduler around an FHT core. It loads N = 4*2^A_BIT samples into four banks in bit-reversed order,
// starts the transform, then unloads the banks in natural order. Load writes come 1 cycle after each accept;
// read data is valid 1 cycle after each read enable. in_ready is high only while idle or loading; unload reads are paced by the consumer credit iOUT_READY.
module fht_frame_sched #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iIN_VALID,
    input  logic [D_BIT-1:0] iIN_DATA,
    output logic             oIN_READY,
    output logic             oLOAD_WE,
    output logic [1:0]       oLOAD_BANK,
    output logic [A_BIT-1:0] oLOAD_ADDR,
    output logic [D_BIT-1:0] oLOAD_DATA,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic [1:0]       oSRC_SEL,
    input  logic             iOUT_READY,
    output logic             oUNLOAD_RE,
    output logic [1:0]       oUNLOAD_BANK,
    output logic [A_BIT-1:0] oUNLOAD_ADDR,
    output logic             oOUT_VALID,
    output logic             oBUSY,
    output logic             oFRAME_DONE,
    output logic             oERR,
    input  logic             iCLR_ERR
);

    localparam int             K_W    = A_BIT + 2;
    localparam logic [K_W-1:0] K_LAST = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_UNLOAD,
        ST_DRAIN
    } state_t;

    state_t           state;
    logic [K_W-1:0]   k;
    logic [K_W-1:0]   k_rev;
    logic [2:0]       wb_cnt;
    logic             accept;
    logic             unload_re;
    logic             timeout;

    logic             load_we;
    logic [1:0]       load_bank;
    logic [A_BIT-1:0] load_addr;
    logic [D_BIT-1:0] load_data;
    logic             fht_start;
    logic [1:0]       src_sel;
    logic             out_valid;
    logic             frame_done;
    logic             err;

    // Reset takes priority over any handshake, so nothing is accepted or read while it is high.
    assign oIN_READY  = ((state == ST_IDLE) || (state == ST_LOAD)) && !iRESET;
    assign accept     = iIN_VALID && oIN_READY;
    assign unload_re  = (state == ST_UNLOAD) && iOUT_READY && !iRESET;
    // The FHT core never dropped ready during 8 consecutive cycles after start.
    assign timeout    = (state == ST_WAIT_BUSY) && iFHT_RDY && (wb_cnt == 3'd7);

    assign oUNLOAD_RE   = unload_re;
    assign oUNLOAD_BANK = (state == ST_UNLOAD) ? k[K_W-1:A_BIT] : 2'd0;
    assign oUNLOAD_ADDR = (state == ST_UNLOAD) ? k[A_BIT-1:0]   : '0;
    assign oBUSY        = (state != ST_IDLE);

    assign oLOAD_WE    = load_we;
    assign oLOAD_BANK  = load_bank;
    assign oLOAD_ADDR  = load_addr;
    assign oLOAD_DATA  = load_data;
    assign oFHT_START  = fht_start;
    assign oSRC_SEL    = src_sel;
    assign oOUT_VALID  = out_valid;
    assign oFRAME_DONE = frame_done;
    assign oERR        = err;

    // Bit-reverse the sample index to get the scrambled load location.
    always_comb begin
        k_rev = '0;
        for (int i = 0; i < K_W; i++) begin
            k_rev[i] = k[K_W-1-i];
        end
    end

    // Load write port: one registered write per accepted sample.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            load_we   <= 1'b0;
            load_bank <= 2'd0;
            load_addr <= '0;
            load_data <= '0;
        end else begin
            load_we <= accept;
            if (accept) begin
                load_bank <= k_rev[K_W-1:A_BIT];
                load_addr <= k_rev[A_BIT-1:0];
                load_data <= iIN_DATA;
            end
        end
    end

    // Frame sequencing FSM with its registered control outputs.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state      <= ST_IDLE;
            k          <= '0;
            wb_cnt     <= 3'd0;
            src_sel    <= 2'd0;
            fht_start  <= 1'b0;
            frame_done <= 1'b0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            fht_start  <= 1'b0;
            frame_done <= 1'b0;
            out_valid  <= unload_re;

            // A timeout in the same cycle as a clear leaves the error set.
            if (timeout) begin
                err <= 1'b1;
            end else if (iCLR_ERR) begin
                err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        k     <= k + K_W'(1);
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        k <= k + K_W'(1);
                        if (k == K_LAST) begin
                            state     <= ST_START;
                            fht_start <= 1'b1;
                            src_sel   <= 2'd1;
                        end
                    end
                end
                ST_START: begin
                    wb_cnt <= 3'd0;
                    state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!iFHT_RDY) begin
                        state <= ST_WAIT_DONE;
                    end else if (wb_cnt == 3'd7) begin
                        state   <= ST_IDLE;
                        src_sel <= 2'd0;
                    end else begin
                        wb_cnt <= wb_cnt + 3'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (iFHT_RDY) begin
                        state   <= ST_UNLOAD;
                        src_sel <= 2'd2;
                    end
                end
                ST_UNLOAD: begin
                    if (unload_re) begin
                        k <= k + K_W'(1);
                        if (k == K_LAST) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    frame_done <= 1'b1;
                    src_sel    <= 2'd0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fht_frame_sched.sv
// Bench for fht_frame_sched with A_BIT=2 (N=16): a frame-level reference model plus per-frame literal checks.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Frames cover held and toggled valid, FHT timeout with clear races, and resets mid-frame.
module tb_fht_frame_sched;

    localparam int A_BIT = 2;
    localparam int D_BIT = 16;
    localparam int DEPTH = 4;
    localparam int N     = 16;

    localparam int P_ACC   = 0;
    localparam int P_START = 1;
    localparam int P_WB    = 2;
    localparam int P_WD    = 3;
    localparam int P_UNL   = 4;
    localparam int P_DRAIN = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [D_BIT-1:0] in_data;
    logic             fht_rdy;
    logic             out_ready;
    logic             clr_err;

    logic             in_ready;
    logic             load_we;
    logic [1:0]       load_bank;
    logic [A_BIT-1:0] load_addr;
    logic [D_BIT-1:0] load_data;
    logic             fht_start;
    logic [1:0]       src_sel;
    logic             unload_re;
    logic [1:0]       unload_bank;
    logic [A_BIT-1:0] unload_addr;
    logic             out_valid;
    logic             busy;
    logic             frame_done;
    logic             err;

    always #5 clk = ~clk;

    fht_frame_sched #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
        .iCLK         (clk),
        .iRESET       (rst),
        .iIN_VALID    (in_valid),
        .iIN_DATA     (in_data),
        .oIN_READY    (in_ready),
        .oLOAD_WE     (load_we),
        .oLOAD_BANK   (load_bank),
        .oLOAD_ADDR   (load_addr),
        .oLOAD_DATA   (load_data),
        .oFHT_START   (fht_start),
        .iFHT_RDY     (fht_rdy),
        .oSRC_SEL     (src_sel),
        .iOUT_READY   (out_ready),
        .oUNLOAD_RE   (unload_re),
        .oUNLOAD_BANK (unload_bank),
        .oUNLOAD_ADDR (unload_addr),
        .oOUT_VALID   (out_valid),
        .oBUSY        (busy),
        .oFRAME_DONE  (frame_done),
        .oERR         (err),
        .iCLR_ERR     (clr_err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < A_BIT + 2; i++) begin
            if (v[i]) r = r | (1 << (A_BIT + 1 - i));
        end
        return r;
    endfunction

    // Reference model: phase of the frame and what each output must show after this edge.
    int               m_phase  = P_ACC;
    int               m_cnt    = 0;
    int               m_wb     = 0;
    int               m_rd     = 0;
    bit               m_err    = 1'b0;
    bit               m_we     = 1'b0;
    bit               m_ov     = 1'b0;
    bit               m_done   = 1'b0;
    int               m_we_idx = 0;
    logic [D_BIT-1:0] m_we_dat = '0;

    always @(posedge clk) begin : model
        bit acc;
        bit re;
        bit tmo;
        cyc++;
        started = 1'b1;
        if (rst) begin
            m_phase = P_ACC;
            m_cnt   = 0;
            m_rd    = 0;
            m_err   = 1'b0;
            m_we    = 1'b0;
            m_ov    = 1'b0;
            m_done  = 1'b0;
        end else begin
            acc = (m_phase == P_ACC) && (in_valid === 1'b1);
            re  = (m_phase == P_UNL) && (out_ready === 1'b1);
            tmo = 1'b0;
            m_we     = acc;
            m_we_idx = m_cnt;
            m_we_dat = in_data;
            m_ov     = re;
            m_done   = (m_phase == P_DRAIN);
            case (m_phase)
                P_ACC: begin
                    if (acc) begin
                        m_cnt++;
                        if (m_cnt == N) begin
                            m_cnt   = 0;
                            m_phase = P_START;
                        end
                    end
                end
                P_START: begin
                    m_wb    = 0;
                    m_phase = P_WB;
                end
                P_WB: begin
                    if (!fht_rdy) begin
                        m_phase = P_WD;
                    end else begin
                        m_wb++;
                        if (m_wb == 8) begin
                            tmo     = 1'b1;
                            m_phase = P_ACC;
                        end
                    end
                end
                P_WD: begin
                    if (fht_rdy) begin
                        m_phase = P_UNL;
                        m_rd    = 0;
                    end
                end
                P_UNL: begin
                    if (re) begin
                        m_rd++;
                        if (m_rd == N) m_phase = P_DRAIN;
                    end
                end
                default: m_phase = P_ACC;
            endcase
            if (tmo) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
        end
    end

    // Event logs taken from the DUT for the per-frame literal checks.
    int               we_cnt, start_cnt, re_cnt, done_cnt, last_re_cyc, done_cyc;
    logic [N-1:0]     wmask;
    logic [1:0]       log_bank [N];
    logic [A_BIT-1:0] log_addr [N];
    logic [D_BIT-1:0] log_dat  [N];

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin : cmp
        bit e_rdy;
        bit e_re;
        int e_src;
        int idx;
        if (started) begin
            e_rdy = (m_phase == P_ACC) && !rst;
            e_re  = (m_phase == P_UNL) && (out_ready === 1'b1) && !rst;
            e_src = (m_phase == P_ACC) ? 0 : ((m_phase >= P_UNL) ? 2 : 1);
            chk("in_ready", in_ready, e_rdy);
            chk("load_we", load_we, m_we);
            if (m_we) begin
                chk("load_bank", load_bank, bitrev(m_we_idx) / DEPTH);
                chk("load_addr", load_addr, bitrev(m_we_idx) % DEPTH);
                chk("load_data", load_data, m_we_dat);
            end
            chk("fht_start", fht_start, m_phase == P_START);
            chk("src_sel", src_sel, e_src);
            chk("unload_re", unload_re, e_re);
            if (e_re) begin
                chk("unload_bank", unload_bank, m_rd / DEPTH);
                chk("unload_addr", unload_addr, m_rd % DEPTH);
            end
            chk("out_valid", out_valid, m_ov);
            chk("busy", busy, !((m_phase == P_ACC) && (m_cnt == 0)));
            chk("frame_done", frame_done, m_done);
            chk("err", err, m_err);

            if (load_we === 1'b1) begin
                if (we_cnt < N) begin
                    log_bank[we_cnt] = load_bank;
                    log_addr[we_cnt] = load_addr;
                    log_dat[we_cnt]  = load_data;
                end
                idx = int'(load_bank) * DEPTH + int'(load_addr);
                wmask[idx] = 1'b1;
                we_cnt++;
            end
            if (fht_start === 1'b1) start_cnt++;
            if (unload_re === 1'b1) begin
                re_cnt++;
                last_re_cyc = cyc;
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        we_cnt      = 0;
        start_cnt   = 0;
        re_cnt      = 0;
        done_cnt    = 0;
        last_re_cyc = 0;
        done_cyc    = 0;
        wmask       = '0;
    endtask

    // Offers N samples; returns in the cycle right after the last accept.
    task automatic load_frame(input int base, input bit toggle);
        for (int s = 0; s < N; s++) begin
            in_data  = D_BIT'(base + s);
            in_valid = 1'b1;
            tick();
            if (toggle && (s != N - 1)) begin
                in_valid = 1'b0;
                tick();
            end
        end
    endtask

    // From the START cycle: FHT drops ready, stays busy, then finishes.
    task automatic run_fht(input int busy_cycles);
        fht_rdy = 1'b0;
        tick();
        repeat (busy_cycles) tick();
        fht_rdy = 1'b1;
        tick();
    endtask

    task automatic unload(input bit patterned);
        int got;
        int ph;
        got = 0;
        ph  = 0;
        for (int c = 0; c < 60 && got < N; c++) begin
            out_ready = patterned ? (ph != 1) : 1'b1;
            if (out_ready) got++;
            ph = (ph + 1) % 4;
            tick();
        end
        out_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_check(input string tag);
        chk({tag, "_re_count"}, re_cnt, N);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_lag"}, done_cyc - last_re_cyc, 2);
        chk({tag, "_start_count"}, start_cnt, 1);
        chk({tag, "_we_count"}, we_cnt, N);
        chk({tag, "_wmask"}, wmask, 16'hFFFF);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        fht_rdy   = 1'b1;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        clear_logs();

        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_src_sel", src_sel, 0);
        chk("rst_err", err, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Frame 1: valid held high throughout, stray out_ready during load.
        clear_logs();
        out_ready = 1'b1;
        load_frame(0, 1'b0);
        chk("f1_start_pulse", fht_start, 1);
        chk("f1_in_ready_low", in_ready, 0);
        run_fht(3);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("f1_w1_bank", log_bank[1], 2);
        chk("f1_w1_addr", log_addr[1], 0);
        chk("f1_w1_data", log_dat[1], 1);
        chk("f1_w3_bank", log_bank[3], 3);
        chk("f1_w3_addr", log_addr[3], 0);
        chk("f1_w5_bank", log_bank[5], 2);
        chk("f1_w5_addr", log_addr[5], 2);
        chk("f1_w5_data", log_dat[5], 5);
        unload(1'b1);
        frame_check("f1");

        // Frame 2: valid toggling, continuous unload.
        clear_logs();
        load_frame(16'h0100, 1'b1);
        in_valid = 1'b0;
        chk("f2_start_pulse", fht_start, 1);
        run_fht(2);
        unload(1'b0);
        frame_check("f2");

        // Frame 3: FHT never goes busy, timeout and error clear, then a normal frame.
        clear_logs();
        load_frame(16'h0200, 1'b0);
        in_valid = 1'b0;
        repeat (9) tick();
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_src_sel", src_sel, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err", err, 0);
        clear_logs();
        load_frame(16'h0280, 1'b0);
        in_valid = 1'b0;
        run_fht(2);
        unload(1'b1);
        frame_check("f3");

        // Frame 4: clear coincides with the timeout edge.
        clear_logs();
        load_frame(16'h0300, 1'b0);
        in_valid = 1'b0;
        tick();
        repeat (7) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("race_err", err, 1);
        chk("race_busy", busy, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("race_cleared", err, 0);

        // Reset mid-load at k=7, then mid WAIT_DONE, then a clean frame.
        clear_logs();
        in_valid = 1'b1;
        for (int s = 0; s < 7; s++) begin
            in_data = D_BIT'(16'h0350 + s);
            tick();
        end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_load_src", src_sel, 0);
        chk("rst_load_busy", busy, 0);
        chk("rst_load_we", load_we, 0);
        tick();
        clear_logs();
        load_frame(16'h0400, 1'b0);
        in_valid = 1'b0;
        fht_rdy  = 1'b0;
        tick();
        repeat (3) tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_wd_src", src_sel, 0);
        chk("rst_wd_busy", busy, 0);
        chk("rst_wd_re", unload_re, 0);
        out_ready = 1'b0;
        fht_rdy   = 1'b1;
        repeat (3) tick();
        chk("rst_wd_starts", start_cnt, 1);
        chk("rst_wd_re_count", re_cnt, 0);
        chk("rst_wd_done_count", done_cnt, 0);
        clear_logs();
        load_frame(16'h0500, 1'b0);
        in_valid = 1'b0;
        run_fht(4);
        unload(1'b1);
        frame_check("f5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
